memory_loader: RTL and testbench

MEMORY_LOADER -- requirements
Module: memory_loader

---
 rtl/memory_loader_pkg.sv | 19 +
 rtl/memory_loader.sv | 85 ++++++++
 tb/tb_memory_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/memory_loader_pkg.sv
// Shared defaults, fixed-point constants (3 fractional bits) and FSM state
// encoding for the X/W memory loader.
package memory_loader_pkg;

    localparam int WIDTH = 5;
    localparam int NX    = 4;
    localparam int NW    = NX * NX;

    localparam logic [WIDTH-1:0] ONE         = 5'b01000;
    localparam logic [WIDTH-1:0] NEG_QUARTER = 5'b11110;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_X,
        LOAD_W,
        DONE
    } state_t;

endpackage

// File: rtl/memory_loader.sv
// Streams NX input-vector words followed by NW row-major weight words into
// flat register banks, one accepted word per valid cycle.
module memory_loader
    import memory_loader_pkg::*;
#(
    parameter int WIDTH = memory_loader_pkg::WIDTH,
    parameter int NX    = memory_loader_pkg::NX,
    parameter int NW    = memory_loader_pkg::NW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic [NX*WIDTH-1:0]   x_flat,
    output logic [NW*WIDTH-1:0]   w_flat
);

    localparam int CW = $clog2(NW);

    state_t        state;
    logic [CW-1:0] cnt;

    // Handshake flags are registered alongside the state so they always
    // describe the state currently held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            x_flat   <= '0;
            w_flat   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD_X;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                LOAD_X: begin
                    if (in_valid && in_ready) begin
                        x_flat[cnt*WIDTH +: WIDTH] <= in_data;
                        if (cnt == CW'(NX-1)) begin
                            state <= LOAD_W;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LOAD_W: begin
                    if (in_valid && in_ready) begin
                        w_flat[cnt*WIDTH +: WIDTH] <= in_data;
                        if (cnt == CW'(NW-1)) begin
                            state    <= DONE;
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_loader.sv
// Directed bench for memory_loader: a queue scoreboard of expected writes plus
// a behavioural model of the load handshake and storage contents.
module tb_memory_loader;
    import memory_loader_pkg::*;

    localparam int W  = 5;
    localparam int NXT = 4;
    localparam int NWT = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic [W-1:0]       in_data = '0;
    logic               in_ready;
    logic               busy;
    logic               done;
    logic [NXT*W-1:0]   x_flat;
    logic [NWT*W-1:0]   w_flat;

    memory_loader #(.WIDTH(W), .NX(NXT), .NW(NWT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .x_flat   (x_flat),
        .w_flat   (w_flat)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_w;
        int           idx;
        logic [W-1:0] val;
    } wr_t;

    wr_t              q[$];
    int               vectors = 0;
    int               miscompares = 0;
    int               ms = 0;   // 0 idle, 1 load X, 2 load W, 3 done
    int               mc = 0;
    logic [NXT*W-1:0] mx = '0;
    logic [NWT*W-1:0] mw = '0;

    task automatic check(input string tag, input logic [NWT*W-1:0] obs,
                         input logic [NWT*W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [2:0] fl;
        fl = {ms == 1 || ms == 2, ms == 1 || ms == 2, ms == 3};
        check({tag, " flags"}, {77'd0, in_ready, busy, done}, {77'd0, fl});
        check({tag, " x_flat"}, {60'd0, x_flat}, {60'd0, mx});
        check({tag, " w_flat"}, w_flat, mw);
    endtask

    // One clock cycle of stimulus; the model decides whether the word is taken.
    task automatic cyc(input bit s, input bit v, input logic [W-1:0] d);
        wr_t e;
        start = s; in_valid = v; in_data = d;
        case (ms)
            0, 3: if (s) begin ms = 1; mc = 0; end
            1: if (v) begin
                q.push_back('{1'b0, mc, d});
                mx[mc*W +: W] = d;
                if (mc == NXT-1) begin ms = 2; mc = 0; end else mc++;
            end
            2: if (v) begin
                q.push_back('{1'b1, mc, d});
                mw[mc*W +: W] = d;
                if (mc == NWT-1) begin ms = 3; mc = 0; end else mc++;
            end
            default: ;
        endcase
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        if (q.size() != 0) begin
            e = q.pop_front();
            if (e.is_w)
                check("w entry", {75'd0, w_flat[e.idx*W +: W]}, {75'd0, e.val});
            else
                check("x entry", {75'd0, x_flat[e.idx*W +: W]}, {75'd0, e.val});
        end
        check_all("cycle");
    endtask

    // Asserted mid-cycle so the clear is observed before any clock edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        ms = 0; mc = 0; mx = '0; mw = '0; q.delete();
        check_all("async reset");
        @(posedge clk); #1 rst = 1'b0;
        check_all("after reset");
    endtask

    function automatic logic [W-1:0] word(input int k);
        if (k < NXT) return W'(k + 1);
        return ((k - NXT) % 5 == 0) ? ONE : NEG_QUARTER;
    endfunction

    int ncyc;

    initial begin
        rst = 1'b1;
        #12;
        check_all("reset state");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back load: done appears on the 21st edge counting start.
        cyc(1'b1, 1'b0, '0);
        for (int k = 0; k < NXT + NWT; k++) begin
            if (k == NXT + NWT - 1) check("done early", {79'd0, done}, 80'd0);
            cyc(1'b0, 1'b1, word(k));
        end
        check("done cyc21", {79'd0, done}, 80'd1);
        check("x pattern", {60'd0, x_flat}, 80'h20C41);
        check("w diag5", {75'd0, w_flat[5*W +: W]}, {75'd0, ONE});
        check("w off1", {75'd0, w_flat[1*W +: W]}, {75'd0, NEG_QUARTER});

        // Gapped load with junk on idle cycles; nothing extra may land.
        cyc(1'b1, 1'b0, '0);
        ncyc = 0;
        for (int k = 0; k < NXT + NWT; k++) begin
            cyc(1'b0, 1'b1, word(k));
            cyc(1'b0, 1'b0, W'($urandom));
            ncyc += 2;
        end
        check("gapped done", {79'd0, done}, 80'd1);
        check("gapped cycles", 80'(ncyc), 80'd40);

        // Start pulse with cnt=7 in LOAD_W must not disturb the sequence.
        cyc(1'b1, 1'b0, '0);
        for (int k = 0; k < NXT + NWT; k++)
            cyc(k == NXT + 7, 1'b1, word(NXT + NWT - 1 - k));
        check("start ignored done", {79'd0, done}, 80'd1);

        // Reset after 10 words, then valid words in IDLE are ignored.
        cyc(1'b1, 1'b0, '0);
        for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, word(k));
        async_reset();
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 5'b10101);
        check("idle ready", {79'd0, in_ready}, 80'd0);

        // Full load, then restart from DONE with X=11111 while W is kept.
        cyc(1'b1, 1'b0, '0);
        for (int k = 0; k < NXT + NWT; k++) cyc(1'b0, 1'b1, word(k));
        cyc(1'b0, 1'b1, 5'b10101);
        cyc(1'b1, 1'b0, '0);
        check("restart done low", {79'd0, done}, 80'd0);
        for (int k = 0; k < NXT; k++) cyc(1'b0, 1'b1, 5'b11111);
        check("restart x", {60'd0, x_flat}, 80'hFFFFF);
        check("restart w kept", {75'd0, w_flat[10*W +: W]}, {75'd0, ONE});
        check("scoreboard drained", 80'(q.size()), 80'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
